// File: rtl/ddr_input_capture.sv
// DDR input capture register: samples D on both edges of C and presents the pair
// as two single-rate buses. Optional synchronous set port S is enabled by `define IDDR_SET_EN.
module ddr_input_capture #(
  parameter int          WIDTH        = 1,
  parameter string       DDR_CLK_EDGE = "SAME_EDGE",
  parameter logic        INIT_Q1      = 1'b0,
  parameter logic        INIT_Q2      = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
`ifdef IDDR_SET_EN
  input  logic             S,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
);

  logic set_cmd;
`ifdef IDDR_SET_EN
  assign set_cmd = S;
`else
  assign set_cmd = 1'b0;
`endif

  // Every stage shares the same per-edge priority: reset, then set, then enable, else hold.
  function automatic logic [WIDTH-1:0] stage_next(
    input logic             rst_c,
    input logic             set_c,
    input logic             en_c,
    input logic [WIDTH-1:0] d_in,
    input logic [WIDTH-1:0] q_cur
  );
    if (rst_c)      return '0;
    else if (set_c) return '1;
    else if (en_c)  return d_in;
    return q_cur;
  endfunction

  logic [WIDTH-1:0] rise_p0 = {WIDTH{INIT_Q1}};
  logic [WIDTH-1:0] fall_p0 = {WIDTH{INIT_Q2}};

  // Stage p0: rising-edge and falling-edge capture of the DDR bus
  always_ff @(posedge C) begin
    rise_p0 <= stage_next(R, set_cmd, CE, D, rise_p0);
  end

  always_ff @(negedge C) begin
    fall_p0 <= stage_next(R, set_cmd, CE, D, fall_p0);
  end

  // Stage p1: re-time onto the rising edge, only built where the output mode needs it
  generate
    if (DDR_CLK_EDGE == "OPPOSITE_EDGE") begin : g_opposite
      assign Q1 = rise_p0;
      assign Q2 = fall_p0;
    end else if (DDR_CLK_EDGE == "SAME_EDGE") begin : g_same
      logic [WIDTH-1:0] fall_p1 = {WIDTH{INIT_Q2}};
      always_ff @(posedge C) begin
        fall_p1 <= stage_next(R, set_cmd, CE, fall_p0, fall_p1);
      end
      assign Q1 = rise_p0;
      assign Q2 = fall_p1;
    end else if (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED") begin : g_pipelined
      logic [WIDTH-1:0] fall_p1 = {WIDTH{INIT_Q2}};
      logic [WIDTH-1:0] rise_p1 = {WIDTH{INIT_Q1}};
      always_ff @(posedge C) begin
        fall_p1 <= stage_next(R, set_cmd, CE, fall_p0, fall_p1);
        rise_p1 <= stage_next(R, set_cmd, CE, rise_p0, rise_p1);
      end
      assign Q1 = rise_p1;
      assign Q2 = fall_p1;
    end else begin : g_bad_mode
      $error("ddr_input_capture: illegal DDR_CLK_EDGE value");
      assign Q1 = '0;
      assign Q2 = '0;
    end
  endgenerate

endmodule

// File: tb/tb_ddr_input_capture.sv
// Bench for ddr_input_capture: all three alignment modes side by side, directed cases
// followed by randomized traffic checked against an edge-level behavioural model.
module tb_ddr_input_capture;

  localparam int W = 4;

  logic         C  = 1'b0;
  logic         R  = 1'b1;
  logic         CE = 1'b0;
  logic         S  = 1'b0;
  logic [W-1:0] D  = '0;
  logic [W-1:0] q1_opp, q2_opp, q1_same, q2_same, q1_pipe, q2_pipe;

  int n_checks = 0;
  int n_errors = 0;
  bit next_is_rise = 1'b1;

  always #5 C = ~C;

  ddr_input_capture #(.WIDTH(W), .DDR_CLK_EDGE("OPPOSITE_EDGE")) u_opp (
    .C(C), .R(R), .CE(CE),
`ifdef IDDR_SET_EN
    .S(S),
`endif
    .D(D), .Q1(q1_opp), .Q2(q2_opp));

  ddr_input_capture #(.WIDTH(W), .DDR_CLK_EDGE("SAME_EDGE")) u_same (
    .C(C), .R(R), .CE(CE),
`ifdef IDDR_SET_EN
    .S(S),
`endif
    .D(D), .Q1(q1_same), .Q2(q2_same));

  ddr_input_capture #(.WIDTH(W), .DDR_CLK_EDGE("SAME_EDGE_PIPELINED")) u_pipe (
    .C(C), .R(R), .CE(CE),
`ifdef IDDR_SET_EN
    .S(S),
`endif
    .D(D), .Q1(q1_pipe), .Q2(q2_pipe));

  // Reference model: the value held by each named stage, updated per the per-edge priority rule.
  logic [W-1:0] m_p = '0, m_n = '0, m_nr = '0, m_pr = '0;

  function automatic logic [W-1:0] upd(input logic [W-1:0] held, input logic [W-1:0] load);
    logic set_now;
`ifdef IDDR_SET_EN
    set_now = S;
`else
    set_now = 1'b0;
`endif
    if (R)            return '0;
    if (set_now)      return '1;
    if (CE)           return load;
    return held;
  endfunction

  always @(posedge C) begin
    m_pr = upd(m_pr, m_p);
    m_nr = upd(m_nr, m_n);
    m_p  = upd(m_p, D);
  end

  always @(negedge C) begin
    m_n = upd(m_n, D);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".opp.q1"},  q1_opp,  m_p);
    check({tag, ".opp.q2"},  q2_opp,  m_n);
    check({tag, ".same.q1"}, q1_same, m_p);
    check({tag, ".same.q2"}, q2_same, m_nr);
    check({tag, ".pipe.q1"}, q1_pipe, m_pr);
    check({tag, ".pipe.q2"}, q2_pipe, m_nr);
  endtask

  // Drive inputs mid-phase, then advance to 1 time unit after the next edge of C.
  task automatic step(input logic [W-1:0] d, input logic ce, input logic r, input logic s);
    #2;
    D = d; CE = ce; R = r; S = s;
    @(posedge C or negedge C);
    #1;
    next_is_rise = ~next_is_rise;
  endtask

  task automatic align_rise(input logic [W-1:0] d);
    if (!next_is_rise) step(d, CE, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    check("power_up.same.q1", q1_same, 4'h0);
    check("power_up.pipe.q2", q2_pipe, 4'h0);

    // Hold reset across one full cycle
    step(4'h9, 1'b1, 1'b1, 1'b0);
    step(4'h9, 1'b1, 1'b1, 1'b0);
    check_model("reset");

    // A before posedge, 5 before negedge, 3 before next posedge
    step(4'hA, 1'b1, 1'b0, 1'b0);
    step(4'h5, 1'b1, 1'b0, 1'b0);
    step(4'h3, 1'b1, 1'b0, 1'b0);
    check("seq.same.q1", q1_same, 4'h3);
    check("seq.same.q2", q2_same, 4'h5);
    check("seq.pipe.q1", q1_pipe, 4'hA);
    check("seq.pipe.q2", q2_pipe, 4'h5);
    step(4'hC, 1'b1, 1'b0, 1'b0);
    check("opp_neg.q2", q2_opp, 4'hC);
    check("opp_neg.q1", q1_opp, 4'h3);
    check("opp_neg.same.q2", q2_same, 4'h5);
    step(4'h7, 1'b1, 1'b0, 1'b0);
    check("seq3.pipe.q1", q1_pipe, 4'h3);
    check("seq3.pipe.q2", q2_pipe, 4'hC);
    check("seq3.same.q1", q1_same, 4'h7);

    // CE low for three cycles while D toggles: every output holds
    for (int i = 0; i < 6; i++) step((i % 2) ? 4'h0 : 4'hF, 1'b0, 1'b0, 1'b0);
    check("hold.opp.q1",  q1_opp,  4'h7);
    check("hold.opp.q2",  q2_opp,  4'hC);
    check("hold.same.q1", q1_same, 4'h7);
    check("hold.same.q2", q2_same, 4'hC);
    check("hold.pipe.q1", q1_pipe, 4'h3);
    check("hold.pipe.q2", q2_pipe, 4'hC);

    // Stream F, then a one-posedge reset with CE low
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
    align_rise(4'hF);
    step(4'hF, 1'b0, 1'b1, 1'b0);
    check("rst.same.q1", q1_same, 4'h0);
    check("rst.same.q2", q2_same, 4'h0);
    check("rst.pipe.q1", q1_pipe, 4'h0);
    check("rst.pipe.q2", q2_pipe, 4'h0);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    check("rst_neg.opp.q2", q2_opp, 4'hF);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    check("resume.same.q1", q1_same, 4'hF);
    check("resume.same.q2", q2_same, 4'hF);
    check("resume.pipe.q1", q1_pipe, 4'h0);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    step(4'hF, 1'b1, 1'b0, 1'b0);
    check("flush.pipe.q1", q1_pipe, 4'hF);

`ifdef IDDR_SET_EN
    step(4'h0, 1'b1, 1'b0, 1'b0);
    align_rise(4'h0);
    step(4'h0, 1'b0, 1'b0, 1'b1);
    check("set.same.q1", q1_same, 4'hF);
    check("set.same.q2", q2_same, 4'hF);
    check("set.pipe.q1", q1_pipe, 4'hF);
    step(4'h0, 1'b0, 1'b0, 1'b1);
    check("set.opp.q2", q2_opp, 4'hF);
    step(4'h0, 1'b1, 1'b1, 1'b1);
    check("rst_set.same.q1", q1_same, 4'h0);
    check("rst_set.pipe.q2", q2_pipe, 4'h0);
`endif

    check_model("directed_end");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic         rnd_ce, rnd_r, rnd_s;
      logic [W-1:0] rnd_d;
      rnd_d  = W'($urandom);
      rnd_ce = ($urandom_range(0, 3) != 0);
      rnd_r  = ($urandom_range(0, 19) == 0);
`ifdef IDDR_SET_EN
      rnd_s  = ($urandom_range(0, 19) == 0);
`else
      rnd_s  = 1'b0;
`endif
      step(rnd_d, rnd_ce, rnd_r, rnd_s);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_input_capture.md
Name: ddr_input_capture

Overview:
- Parameterised double-data-rate input capture register, behaviourally equivalent to a vendor IDDR primitive.
- Samples a DDR input bus on both edges of one clock and presents the two samples as two single-rate output buses.
- Used by the 80 MHz to 40 MHz input demultiplexers: Q2 carries the falling-edge (1st-in-time) sample, Q1 the rising-edge (2nd-in-time) sample.

Parameters:
- WIDTH, 1: number of independent data bits captured in parallel.
- DDR_CLK_EDGE, "SAME_EDGE": output alignment mode; one of "OPPOSITE_EDGE", "SAME_EDGE", "SAME_EDGE_PIPELINED".
- INIT_Q1, 1'b0: power-up value of every Q1 bit and its internal stages.
- INIT_Q2, 1'b0: power-up value of every Q2 bit and its internal stages.

Ports:
- C  input  1  capture clock; both edges used.
- R  input  1  synchronous active-high reset; forces all stages to 0.
- CE  input  1  clock enable for data capture.
- S  input  1  synchronous active-high set; forces all stages to 1 (present only with IDDR_SET_EN).
- D  input  WIDTH  DDR data.
- Q1  output  WIDTH  rising-edge sample.
- Q2  output  WIDTH  falling-edge sample.

Behaviour:
- One clock and one reset: C is the only clock, and R is synchronous and active-high.
- Internal stages:
  - rise register P: captures D on posedge C.
  - fall register N: captures D on negedge C.
  - re-time register NR: captures N on posedge C.
  - pipeline register PR: captures P on posedge C.
- Each stage evaluates R, S and CE at its own clock edge. Priority per stage, per edge:
  - R=1: stage becomes 0.
  - else S=1: stage becomes 1.
  - else CE=1: stage loads its input.
  - else: stage holds.
- R and S act even when CE=0. Deasserting R takes effect from the next edge of each stage; there is no asynchronous path.
- Power-up: P, PR and Q1 equal INIT_Q1; N, NR and Q2 equal INIT_Q2.
- Output mapping per DDR_CLK_EDGE:
  - OPPOSITE_EDGE: Q1=P, changing on posedge; Q2=N, changing on negedge.
  - SAME_EDGE: Q1=P and Q2=NR, both changing on posedge. After posedge k+1: Q1=D@rise(k+1), Q2=D@fall(k).
  - SAME_EDGE_PIPELINED: Q1=PR and Q2=NR, both changing on posedge. After posedge k+1: Q1=D@rise(k), Q2=D@fall(k), i.e. the pair from cycle k together.
- Latency from the sampling edge to the output:
  - OPPOSITE_EDGE: 0 cycles for both Q1 and Q2.
  - SAME_EDGE: Q1 0 cycles; Q2 half a cycle.
  - SAME_EDGE_PIPELINED: Q1 1 cycle; Q2 half a cycle.
- Bits are fully independent; there is no cross-bit logic.
- An illegal DDR_CLK_EDGE string is an elaboration error, raised through $error in a generate-else branch.
- Reset in mid-stream: during R=1 every stage is 0 from the first edge it sees R high.
  - In SAME_EDGE modes, Q1 and Q2 are both 0 after the first posedge with R=1.
  - After R falls, valid data reappears following the normal latency; the pipelined modes need one more posedge to flush.

Optional Feature:
- Macro IDDR_SET_EN.
- Defined: port S exists and behaves as above, with R taking priority over S.
- Undefined: port S is absent and the set path is removed; stages reset to 0 only, otherwise identical timing.

Test Plan:
- SAME_EDGE, WIDTH=4, CE=1: D=4'hA before posedge 1, 4'h5 before negedge 1, 4'h3 before posedge 2 -> after posedge 2, Q2=4'h5 and Q1=4'h3.
- SAME_EDGE_PIPELINED with the same stimulus -> after posedge 2, Q1=4'hA and Q2=4'h5; after posedge 3, Q1=4'h3.
- OPPOSITE_EDGE: D=4'hC at negedge -> Q2=4'hC immediately after that negedge; Q1 changes only on posedges.
- CE=0 for 3 cycles while D toggles 4'hF/4'h0 -> Q1 and Q2 hold their prior values.
- Streaming 4'hF on both edges, assert R for one posedge -> Q1=Q2=0 after that posedge, including with CE=0; data resumes at normal latency after R drops.
- With IDDR_SET_EN: S=1 -> outputs become 4'hF; R=1 and S=1 together -> outputs 0.
